fa_bist_checker: RTL

FA_BIST_CHECKER -- requirements
Module: fa_bist_checker

---
 rtl/fa_bist_pkg.sv | 28 ++
 rtl/fa_bist_ref.sv | 21 ++
 rtl/fa_bist_checker.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fa_bist_pkg.sv
// ---------------------------------------------------------------------------
// fa_bist_pkg
// Shared definitions for the full-adder BIST checker: FSM state encoding,
// stimulus vector width, number of vectors in a run and settle counter width.
// ---------------------------------------------------------------------------
package fa_bist_pkg;

    // Stimulus vector is {A, B, Cin}.
    localparam int VEC_W    = 3;
    localparam int NUM_VECS = 8;

    // Settle counter is wide enough for the largest legal SETTLE_CYCLES (15).
    localparam int CNT_W    = 4;

    // Mismatch counter covers 0..NUM_VECS.
    localparam int ERR_W    = 4;

    localparam logic [VEC_W-1:0] VEC_FIRST = VEC_W'(0);
    localparam logic [VEC_W-1:0] VEC_LAST  = VEC_W'(NUM_VECS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_e;

endpackage : fa_bist_pkg

// File: rtl/fa_bist_ref.sv
// ---------------------------------------------------------------------------
// fa_bist_ref
// Golden full-adder model used by the checker to produce the expected
// response for the vector currently applied to the external adder.
//
// Ports:
//   a, b, cin  in   operand bits
//   cout, sum  out  {cout,sum} = a + b + cin
// ---------------------------------------------------------------------------
module fa_bist_ref (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic sum
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : fa_bist_ref

// File: rtl/fa_bist_checker.sv
// ---------------------------------------------------------------------------
// fa_bist_checker
// Exhaustive built-in self test for an external 1-bit full adder. On start
// it walks the vectors {A,B,Cin} = 000..111 in ascending order, holds each
// vector for SETTLE_CYCLES cycles, then samples the adder response for one
// cycle and compares it with the golden model. Mismatches are counted and
// the first failing vector is captured.
//
// Parameters:
//   SETTLE_CYCLES  cycles a vector is held before sampling (1..15)
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   run request
//   dut_a/b/cin out  stimulus to the adder under test (000 when not running)
//   dut_cout    in   carry response from the adder under test
//   dut_sum     in   sum response from the adder under test
//   busy        out  run in progress (SETTLE or CHECK)
//   done        out  run complete, held until next start or reset
//   pass        out  done with zero mismatches
//   err_count   out  number of mismatching vectors (0..8)
//   fail_vec    out  {A,B,Cin} of the first mismatching vector
//   fail_valid  out  fail_vec holds a captured failure
//
// Handshake: start is sampled on every rising edge while busy=0 (IDLE or
// DONE); a sampled start clears the previous results and launches a run on
// that edge. Start is ignored while busy=1. done is a level that stays high,
// with results frozen, until the next accepted start or reset.
// ---------------------------------------------------------------------------
module fa_bist_checker
    import fa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_cin,
    input  logic             dut_cout,
    input  logic             dut_sum,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] fail_vec,
    output logic             fail_valid
);

    // Counter value on the last settle cycle of a vector.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    bist_state_e      state_q,      state_d;
    logic [VEC_W-1:0] vec_q,        vec_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [ERR_W-1:0] err_q,        err_d;
    logic [VEC_W-1:0] fail_vec_q,   fail_vec_d;
    logic             fail_valid_q, fail_valid_d;

    logic ref_cout;
    logic ref_sum;
    logic mismatch;

    // Golden response for the vector currently held in vec_q.
    fa_bist_ref u_ref (
        .a    (vec_q[2]),
        .b    (vec_q[1]),
        .cin  (vec_q[0]),
        .cout (ref_cout),
        .sum  (ref_sum)
    );

    assign mismatch = ({dut_cout, dut_sum} != {ref_cout, ref_sum});

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        fail_vec_d   = fail_vec_q;
        fail_valid_d = fail_valid_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    vec_d        = VEC_FIRST;
                    cnt_d        = '0;
                    err_d        = '0;
                    fail_vec_d   = '0;
                    fail_valid_d = 1'b0;
                    state_d      = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + ERR_W'(1);
                    // Only the first failing vector is kept.
                    if (!fail_valid_q) begin
                        fail_vec_d   = vec_q;
                        fail_valid_d = 1'b1;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + VEC_W'(1);
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
            fail_vec_q   <= '0;
            fail_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            fail_vec_q   <= fail_vec_d;
            fail_valid_q <= fail_valid_d;
        end
    end

    // All outputs are decoded from flops only, so reset clears them at once.
    assign busy       = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done       = (state_q == ST_DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign fail_vec   = fail_vec_q;
    assign fail_valid = fail_valid_q;

    // Stimulus is parked at 000 outside a run.
    assign {dut_a, dut_b, dut_cin} = busy ? vec_q : '0;

endmodule : fa_bist_checker
